// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream FIFO.
// Default widths plus the pointer-width helper.
package axis_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 16;

   // Layout of one stored beat at the default width; the top
   // re-declares the same layout at its own DATA_WIDTH.
   typedef struct packed {
      logic                      last;
      logic [DEF_DATA_WIDTH-1:0] data;
   } axis_entry_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// FIFO storage: registered write port, asynchronous read port.
// Kept separate so it can be swapped for a vendor RAM.
module axis_fifo_ram
   import axis_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH + 1,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = clog2_min1(DEF_DEPTH)
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FWFT FIFO with level and threshold flags.
// Define AXIS_FIFO_WATERMARK_EN to add PEAK_LEVEL / PEAK_CLR.
module axis_sync_fifo
   import axis_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   localparam int LW        = $clog2(DEPTH + 1)
)(
   input  logic                  ACLK,
   input  logic                  ARESET_N,
   input  logic                  FLUSH,
   input  logic [DATA_WIDTH-1:0] S_TDATA,
   input  logic                  S_TLAST,
   input  logic                  S_TVALID,
   output logic                  S_TREADY,
   output logic [DATA_WIDTH-1:0] M_TDATA,
   output logic                  M_TLAST,
   output logic                  M_TVALID,
   input  logic                  M_TREADY,
   output logic [LW-1:0]         LEVEL,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY
`ifdef AXIS_FIFO_WATERMARK_EN
   ,
   input  logic                  PEAK_CLR,
   output logic [LW-1:0]         PEAK_LEVEL
`endif
);

   localparam int PW = clog2_min1(DEPTH);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;

   logic   push, pop, we;
   entry_t wr_entry, rd_entry;

   // Handshake outputs come only from registered state.
   assign S_TREADY = (level_q != LVL_FULL);
   assign M_TVALID = (level_q != '0);

   assign push = S_TVALID & S_TREADY;
   assign pop  = M_TVALID & M_TREADY;
   assign we   = push & ~FLUSH;

   assign wr_entry.last = S_TLAST;
   assign wr_entry.data = S_TDATA;

   axis_fifo_ram #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk   (ACLK),
      .we    (we),
      .waddr (wptr_q),
      .wdata (wr_entry),
      .raddr (rptr_q),
      .rdata (rd_entry)
   );

   assign M_TDATA = rd_entry.data;
   assign M_TLAST = rd_entry.last;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (FLUSH) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         // Explicit wrap so DEPTH need not be a power of two.
         if (push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   assign LEVEL        = level_q;
   assign ALMOST_FULL  = (level_q >= AF_LVL);
   assign ALMOST_EMPTY = (level_q <= AE_LVL);

`ifdef AXIS_FIFO_WATERMARK_EN
   logic [LW-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (PEAK_CLR) begin
         peak_d = level_q;
      end else if (level_q > peak_q) begin
         peak_d = level_q;
      end
   end

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign PEAK_LEVEL = peak_q;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo at DEPTH=5, 8-bit data.
// Also exercises PEAK_LEVEL when AXIS_FIFO_WATERMARK_EN is defined.
module tb_axis_sync_fifo;

   localparam int DW  = 8;
   localparam int DEP = 5;
   localparam int LW  = $clog2(DEP + 1);

   logic          ACLK = 1'b0;
   logic          ARESET_N;
   logic          FLUSH;
   logic [DW-1:0] S_TDATA;
   logic          S_TLAST;
   logic          S_TVALID;
   logic          S_TREADY;
   logic [DW-1:0] M_TDATA;
   logic          M_TLAST;
   logic          M_TVALID;
   logic          M_TREADY;
   logic [LW-1:0] LEVEL;
   logic          ALMOST_FULL;
   logic          ALMOST_EMPTY;
   logic          pclr = 1'b0;
`ifdef AXIS_FIFO_WATERMARK_EN
   logic [LW-1:0] PEAK_LEVEL;
`endif

   always #5 ACLK = ~ACLK;

   axis_sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEP),
      .AF_THRESH  (3),
      .AE_THRESH  (2)
   ) dut (
      .ACLK         (ACLK),
      .ARESET_N     (ARESET_N),
      .FLUSH        (FLUSH),
      .S_TDATA      (S_TDATA),
      .S_TLAST      (S_TLAST),
      .S_TVALID     (S_TVALID),
      .S_TREADY     (S_TREADY),
      .M_TDATA      (M_TDATA),
      .M_TLAST      (M_TLAST),
      .M_TVALID     (M_TVALID),
      .M_TREADY     (M_TREADY),
      .LEVEL        (LEVEL),
      .ALMOST_FULL  (ALMOST_FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY)
`ifdef AXIS_FIFO_WATERMARK_EN
      ,
      .PEAK_CLR     (pclr),
      .PEAK_LEVEL   (PEAK_LEVEL)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW:0] sb[$];
   int mlevel = 0;
   int mpeak  = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs();
      check("s_tready", 32'(S_TREADY), 32'(mlevel != DEP));
      check("m_tvalid", 32'(M_TVALID), 32'(mlevel != 0));
      check("level", 32'(LEVEL), 32'(mlevel));
      check("almost_full", 32'(ALMOST_FULL), 32'(mlevel >= 3));
      check("almost_empty", 32'(ALMOST_EMPTY), 32'(mlevel <= 2));
      if (mlevel != 0 && sb.size() != 0) begin
         check("m_tdata", 32'(M_TDATA), 32'(sb[0][DW-1:0]));
         check("m_tlast", 32'(M_TLAST), 32'(sb[0][DW]));
      end
`ifdef AXIS_FIFO_WATERMARK_EN
      check("peak_level", 32'(PEAK_LEVEL), 32'(mpeak));
`endif
   endtask

   // One clock: check at the falling edge, drive, update model, take edge.
   task automatic cycle(input logic v, input logic [DW-1:0] d,
                        input logic l, input logic r, input logic f);
      bit acc_push, acc_pop;
      @(negedge ACLK);
      check_outs();
      S_TVALID = v;
      S_TDATA  = d;
      S_TLAST  = l;
      M_TREADY = r;
      FLUSH    = f;
      acc_push = v && (mlevel != DEP);
      acc_pop  = r && (mlevel != 0);
      if (pclr) mpeak = mlevel;
      else if (mlevel > mpeak) mpeak = mlevel;
      if (f) begin
         sb.delete();
      end else begin
         if (acc_pop) void'(sb.pop_front());
         if (acc_push) sb.push_back({l, d});
      end
      mlevel = sb.size();
      @(posedge ACLK);
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      ARESET_N = 1'b0;
      FLUSH    = 1'b0;
      S_TDATA  = '0;
      S_TLAST  = 1'b0;
      S_TVALID = 1'b0;
      M_TREADY = 1'b0;
      #3;
      check_outs();
      @(negedge ACLK);
      ARESET_N = 1'b1;

      // Fill to full, then offer a sixth beat that must be refused.
      for (int i = 0; i < DEP; i++) begin
         logic [DW-1:0] d;
         d = DW'(8'h11 * (i + 1));
         cycle(1'b1, d, i[0], 1'b0, 1'b0);
      end
      cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      idle();

      // Drain, plus one extra cycle with nothing to pop.
      for (int i = 0; i < DEP + 1; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      pclr = 1'b1;
      idle();
      pclr = 1'b0;

      // Steady state at level 3: 20 cycles of concurrent push and pop.
      for (int i = 0; i < 3; i++) begin
         logic [DW-1:0] d;
         d = DW'(8'h40 + i);
         cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         logic [DW-1:0] d;
         d = DW'(8'h80 + i);
         cycle(1'b1, d, i[0], 1'b1, 1'b0);
      end

      // Reach full, then push and pop together.
      cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      idle();

      // Flush at level 4 while a beat is offered.
      cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
      idle();

      // Partial burst, then asynchronous reset between edges.
      cycle(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
      @(negedge ACLK);
      check_outs();
      S_TVALID = 1'b1;
      S_TDATA  = 8'hD3;
      #2;
      ARESET_N = 1'b0;
      #1;
      sb.delete();
      mlevel = 0;
      mpeak  = 0;
      check_outs();
      S_TVALID = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESET_N = 1'b1;

      // Normal operation resumes after reset.
      cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle();
      @(negedge ACLK);
      check_outs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
